arm_imm_encoder: RTL and testbench

//  Inverse of the data-processing 32-bit immediate shifter path (shifter_op 3'b001).

---
 rtl/arm_dp_pkg.sv | 15 +
 rtl/imm8_fit_check.sv | 17 +
 rtl/arm_imm_encoder.sv | 122 ++++++++++++
 tb/tb_arm_imm_encoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_dp_pkg.sv
// Shared data-processing definitions for the immediate encoder.
// Holds the immediate shifter opcode, the field widths and the
// encoder FSM state type.
package arm_dp_pkg;
  localparam logic [2:0] SHIFTER_OP_IMM32 = 3'b001;
  localparam int         ROT_W            = 4;
  localparam int         IMM_W            = 8;
  localparam int         DATA_W           = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } enc_state_e;
endpackage

// File: rtl/imm8_fit_check.sv
// Combinational fit test for one candidate rotation.
//   work  in  DATA_W  operand rotated so far
//   fit   out 1       upper bits are all zero, value fits in imm8
//   imm8  out IMM_W   low bits of work
module imm8_fit_check
  import arm_dp_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int IW = IMM_W
) (
  input  logic [DW-1:0] work,
  output logic          fit,
  output logic [IW-1:0] imm8
);
  assign fit  = ~|work[DW-1:IW];
  assign imm8 = work[IW-1:0];
endmodule

// File: rtl/arm_imm_encoder.sv
// Iterative encoder for the 32-bit rotated-immediate operand form:
// finds the smallest rot with value == imm8 ROR (2*rot), testing one
// rotation per cycle.
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_value/in_ready     constant to encode (accepted when idle)
//   out_valid/out_ready            result handshake
//   out_encodable                  1 when an encoding exists
//   out_rot/out_imm8/out_operand   encoding fields, operand = {rot, imm8}
//   out_carry                      shifter carry-out of the encoding
module arm_imm_encoder
  import arm_dp_pkg::*;
#(
  parameter int RW = ROT_W,
  parameter int IW = IMM_W,
  parameter int DW = DATA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [DW-1:0]  in_value,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_encodable,
  output logic [RW-1:0]  out_rot,
  output logic [IW-1:0]  out_imm8,
  output logic [RW+IW-1:0] out_operand,
  output logic           out_carry
);
  enc_state_e    state_q, state_d;
  logic [DW-1:0] work_q, work_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          sign_q, sign_d;
  logic          enc_q, enc_d;
  logic [RW-1:0] rot_q, rot_d;
  logic [IW-1:0] imm8_q, imm8_d;
  logic          carry_q, carry_d;

  logic          fit;
  logic [IW-1:0] fit_imm8;

  imm8_fit_check #(.DW(DW), .IW(IW)) u_fit (
    .work (work_q),
    .fit  (fit),
    .imm8 (fit_imm8)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    enc_d   = enc_q;
    rot_d   = rot_q;
    imm8_d  = imm8_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_value;
          sign_d  = in_value[DW-1];
          cnt_d   = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (fit) begin
          // Ascending cnt guarantees the canonical (smallest) rotation.
          enc_d   = 1'b1;
          rot_d   = cnt_q;
          imm8_d  = fit_imm8;
          carry_d = (cnt_q != '0) & sign_q;
          state_d = DONE;
        end else if (cnt_q == '1) begin
          enc_d   = 1'b0;
          rot_d   = '0;
          imm8_d  = '0;
          carry_d = 1'b0;
          state_d = DONE;
        end else begin
          // Rotating left by 2 undoes one step of the ROR 2*rot.
          work_d = {work_q[DW-3:0], work_q[DW-1:DW-2]};
          cnt_d  = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      enc_q   <= 1'b0;
      rot_q   <= '0;
      imm8_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      enc_q   <= enc_d;
      rot_q   <= rot_d;
      imm8_q  <= imm8_d;
      carry_q <= carry_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign out_encodable = enc_q;
  assign out_rot       = rot_q;
  assign out_imm8      = imm8_q;
  assign out_operand   = {rot_q, imm8_q};
  assign out_carry     = carry_q;
endmodule

// File: tb/tb_arm_imm_encoder.sv
module tb_arm_imm_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_value = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_encodable;
  logic [3:0]  out_rot;
  logic [7:0]  out_imm8;
  logic [11:0] out_operand;
  logic        out_carry;

  arm_imm_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_value(in_value),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_encodable(out_encodable), .out_rot(out_rot), .out_imm8(out_imm8),
    .out_operand(out_operand), .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       enc;
    logic [3:0] rot;
    logic [7:0] imm8;
    logic       carry;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   bp_force = 1'b0;
  bit   mon_en = 1'b0;
  bit   seen = 1'b0;
  bit   idle_chk = 1'b0;
  logic [24:0] held;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror32(logic [31:0] x, int s);
    logic [63:0] d;
    d = {x, x} >> s;
    return d[31:0];
  endfunction

  // Exhaustive search over every (rot, imm8) pair, smallest rot first.
  function automatic exp_t model(logic [31:0] v);
    exp_t e;
    e.enc = 0; e.rot = 0; e.imm8 = 0; e.carry = 0; e.lat = 16; e.acc = 0;
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 256; i++) begin
        if (ror32(32'(i), 2 * r) == v) begin
          e.enc = 1; e.rot = 4'(r); e.imm8 = 8'(i);
          e.carry = (r != 0) && v[31];
          e.lat = r + 1;
          return e;
        end
      end
    end
    return e;
  endfunction

  task automatic send(logic [31:0] v);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
    e = model(v);
    in_valid = 1'b1;
    in_value = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = bp_force ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on the first cycle of each result.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (idle_chk) begin
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        chk("post_hs_out_valid", 32'(out_valid), 32'd0);
        idle_chk = 1'b0;
      end
      if (out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            chk("spurious_out", 32'(out_valid), 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("encodable", 32'(out_encodable), 32'(e.enc));
            chk("rot", 32'(out_rot), 32'(e.rot));
            chk("imm8", 32'(out_imm8), 32'(e.imm8));
            chk("operand", 32'(out_operand), 32'({e.rot, e.imm8}));
            chk("carry", 32'(out_carry), 32'(e.carry));
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          end
          held = {out_encodable, out_operand, out_carry, out_rot, out_imm8[6:0]};
          seen = 1'b1;
        end else begin
          chk("held_stable", 32'({out_encodable, out_operand, out_carry, out_rot, out_imm8[6:0]}),
              32'(held));
        end
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        if (out_ready) begin
          seen = 1'b0;
          idle_chk = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [31:0] dir [6];
    int n;
    dir = '{32'h000000FF, 32'hFF000000, 32'hF000000F, 32'h00000100,
            32'h00000000, 32'h00000101};

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'({out_encodable, out_operand, out_carry}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    foreach (dir[i]) send(dir[i]);
    drain();

    // Backpressure with an ignored input pulse while busy.
    bp_force = 1'b1;
    send(32'h3FC00000);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_value = 32'h12;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    bp_force = 1'b0;
    drain();

    // Random: half guaranteed encodable, half arbitrary words.
    for (int k = 0; k < 150; k++) begin
      logic [31:0] v;
      if (k % 2 == 0) v = ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
      else            v = $urandom;
      send(v);
    end
    drain();

    // Asynchronous reset aborting a search.
    send(32'h00000101);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    chk("async_data", 32'({out_encodable, out_operand, out_carry}), 32'd0);
    void'(sb.pop_back());
    seen = 1'b0;
    idle_chk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'h000000FF);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
